// File: rtl/pwm_duty_sequencer_pkg.sv
// rtl/pwm_duty_sequencer_pkg.sv - shared state encodings for the duty sequencer
package pwm_duty_sequencer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_UP      = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_DOWN    = 3'd3,
        ST_HOLD_LO = 3'd4
    } seq_state_e;

endpackage

// File: rtl/pwm_duty_sequencer_if.sv
// rtl/pwm_duty_sequencer_if.sv - configuration and duty/load bundle between controller and sequencer
interface pwm_duty_sequencer_if #(
    parameter int R_SIZE = 8,
    parameter int RATE_W = 8
) ();
    import pwm_duty_sequencer_pkg::*;

    logic               en;
    logic [R_SIZE-1:0]  fixed_duty;
    logic [R_SIZE-1:0]  duty_min;
    logic [R_SIZE-1:0]  duty_max;
    logic [R_SIZE-1:0]  step;
    logic [RATE_W-1:0]  rate;
    logic [RATE_W-1:0]  hold;
    logic [R_SIZE-1:0]  duty;
    logic               load;
    logic [STATE_W-1:0] state;
    logic               period_tick;

    modport master (
        output en, fixed_duty, duty_min, duty_max, step, rate, hold,
        input  duty, load, state, period_tick
    );

    modport slave (
        input  en, fixed_duty, duty_min, duty_max, step, rate, hold,
        output duty, load, state, period_tick
    );

endinterface

// File: rtl/pwm_duty_sequencer_period_timer.sv
// rtl/pwm_duty_sequencer_period_timer.sv - free-running period counter with end-of-period tick
module pwm_duty_sequencer_period_timer #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst,
    output logic period_tick
);

    logic [W-1:0] p_cnt_q;
    logic [W-1:0] p_cnt_d;

    always_comb begin
        p_cnt_d = p_cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_cnt_q <= '0;
        end else begin
            p_cnt_q <= p_cnt_d;
        end
    end

    assign period_tick = &p_cnt_q;

endmodule

// File: rtl/pwm_duty_sequencer.sv
// rtl/pwm_duty_sequencer.sv - breathing/fixed duty generator presenting one duty load per PWM period
module pwm_duty_sequencer #(
    parameter int R_SIZE = 8,
    parameter int RATE_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    pwm_duty_sequencer_if.slave sif
);
    import pwm_duty_sequencer_pkg::*;

    logic period_tick;

    pwm_duty_sequencer_period_timer #(.W(R_SIZE)) u_period_timer (
        .clk         (clk),
        .rst         (rst),
        .period_tick (period_tick)
    );

    seq_state_e        state_q, state_d;
    logic [R_SIZE-1:0] duty_q, duty_d;
    logic              load_q, load_d;
    logic [RATE_W-1:0] rate_cnt_q, rate_cnt_d;
    logic [RATE_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [R_SIZE-1:0] step_eff;
    logic [R_SIZE-1:0] lo;
    logic [R_SIZE-1:0] hi;
    logic [R_SIZE-1:0] cur;
    logic [R_SIZE:0]   sum;
    logic [R_SIZE:0]   diff;
    logic [R_SIZE-1:0] up_val;
    logic [R_SIZE-1:0] dn_val;
    logic              rate_done;
    logic              hold_done;

    // An inverted or empty window collapses to duty_min so the ramp pins there.
    always_comb begin
        step_eff  = (sif.step == '0) ? R_SIZE'(1) : sif.step;
        lo        = sif.duty_min;
        hi        = (sif.duty_min >= sif.duty_max) ? sif.duty_min : sif.duty_max;
        cur       = (duty_q < lo) ? lo : ((duty_q > hi) ? hi : duty_q);
        sum       = {1'b0, cur} + {1'b0, step_eff};
        diff      = {1'b0, cur} - {1'b0, step_eff};
        up_val    = (sum > {1'b0, hi}) ? hi : sum[R_SIZE-1:0];
        dn_val    = (diff[R_SIZE] || (diff[R_SIZE-1:0] < lo)) ? lo : diff[R_SIZE-1:0];
        rate_done = (rate_cnt_q >= sif.rate);
        hold_done = (hold_cnt_q >= sif.hold);
    end

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        rate_cnt_d = rate_cnt_q;
        hold_cnt_d = hold_cnt_q;
        load_d     = period_tick;
        if (period_tick) begin
            if (!sif.en) begin
                state_d = ST_IDLE;
                duty_d  = sif.fixed_duty;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_d = ST_UP;
                        duty_d  = sif.duty_min;
                    end
                    ST_UP: begin
                        duty_d = cur;
                        if (rate_done) begin
                            rate_cnt_d = '0;
                            duty_d     = up_val;
                            if (up_val == hi) state_d = ST_HOLD_HI;
                        end else begin
                            rate_cnt_d = rate_cnt_q + RATE_W'(1);
                        end
                    end
                    ST_HOLD_HI: begin
                        duty_d = cur;
                        if (hold_done) state_d = ST_DOWN;
                        else           hold_cnt_d = hold_cnt_q + RATE_W'(1);
                    end
                    ST_DOWN: begin
                        duty_d = cur;
                        if (rate_done) begin
                            rate_cnt_d = '0;
                            duty_d     = dn_val;
                            if (dn_val == lo) state_d = ST_HOLD_LO;
                        end else begin
                            rate_cnt_d = rate_cnt_q + RATE_W'(1);
                        end
                    end
                    ST_HOLD_LO: begin
                        duty_d = cur;
                        if (hold_done) state_d = ST_UP;
                        else           hold_cnt_d = hold_cnt_q + RATE_W'(1);
                    end
                    default: begin
                        state_d = ST_IDLE;
                        duty_d  = sif.fixed_duty;
                    end
                endcase
            end
            if (state_d != state_q) begin
                rate_cnt_d = '0;
                hold_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            duty_q     <= '0;
            load_q     <= 1'b0;
            rate_cnt_q <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            load_q     <= load_d;
            rate_cnt_q <= rate_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign sif.duty        = duty_q;
    assign sif.load        = load_q;
    assign sif.state       = state_q;
    assign sif.period_tick = period_tick;

endmodule
